// File: rtl/bus_tx8.sv
// Single-slot byte transmitter for the shared 8-bit tristate bus: handshake in, request/grant, timed drive, turnaround.
// Optional even-parity output is enabled by defining BUS_TX8_PARITY_EN.
module bus_tx8 #(
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic       en,
    output logic [7:0] q,
    output logic       par,
    output logic       strobe,
    output logic       err
);

    localparam logic [7:0] HOLD_C    = 8'(HOLD_CYCLES);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRIVE = 2'd2,
        S_TURN  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] q_q, q_d;
    logic       en_q, en_d;
    logic       req_q, req_d;
    logic       strobe_q, strobe_d;
    logic       err_q, err_d;

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wait_q   <= 8'd0;
            hold_q   <= 8'd0;
            q_q      <= 8'd0;
            en_q     <= 1'b1;
            req_q    <= 1'b0;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            hold_q   <= hold_d;
            q_q      <= q_d;
            en_q     <= en_d;
            req_q    <= req_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
        end
    end

    // Next-state and datapath; the hold counter enters DRIVE at 1 so it counts 1..HOLD_CYCLES
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        hold_d  = hold_q;
        q_d     = q_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_REQ;
                    wait_d  = 8'd0;
                    q_d     = in_data;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                wait_d = 8'(wait_q + 8'd1);
                if (bus_gnt) begin
                    state_d = S_DRIVE;
                    hold_d  = 8'd1;
                end else if (wait_d == TIMEOUT_C) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_DRIVE: begin
                if (!bus_gnt) begin
                    state_d = S_TURN;
                end else if (hold_q == HOLD_C) begin
                    state_d = S_TURN;
                end else begin
                    hold_d = 8'(hold_q + 8'd1);
                end
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output next values, derived from the upcoming state so every output is a flop
    always_comb begin
        en_d     = (state_d != S_DRIVE);
        req_d    = (state_d == S_REQ) || (state_d == S_DRIVE);
        strobe_d = 1'b0;
        err_d    = 1'b0;
        if ((state_d == S_DRIVE) && (hold_d == HOLD_C)) begin
            strobe_d = 1'b1;
        end else begin
            strobe_d = 1'b0;
        end
        if ((state_q == S_REQ) && (state_d == S_IDLE)) begin
            err_d = 1'b1;
        end else if ((state_q == S_DRIVE) && !bus_gnt) begin
            err_d = 1'b1;
        end else begin
            err_d = 1'b0;
        end
    end

    assign in_ready = (state_q == S_IDLE);
    assign bus_req  = req_q;
    assign en       = en_q;
    assign q        = q_q;
    assign strobe   = strobe_q;
    assign err      = err_q;

`ifdef BUS_TX8_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    logic par_q, par_d;

    // Parity only reloads on an accept, so it is stable for the whole drive window
    always_comb begin
        if ((state_q == S_IDLE) && in_valid) begin
            par_d = even_parity(in_data);
        end else begin
            par_d = par_q;
        end
    end

    // Parity register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par = par_q;
`else
    assign par = 1'b0;
`endif

endmodule

// File: tb/tb_bus_tx8.sv
// Directed self-checking bench for bus_tx8 (HOLD_CYCLES=2 main instance, HOLD_CYCLES=4 for grant loss).
module tb_bus_tx8;

    localparam int H = 2;

    logic       clk;
    logic       rst_n;
    logic       in_valid, in_valid4;
    logic [7:0] in_data;
    logic       bus_gnt;
    logic       in_ready, bus_req, en, par, strobe, err;
    logic [7:0] q;
    logic       in_ready4, bus_req4, en4, par4, strobe4, err4;
    logic [7:0] q4;

    int n_cmp = 0;
    int n_bad = 0;

    bus_tx8 #(.HOLD_CYCLES(2), .TIMEOUT(15)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .bus_req(bus_req), .bus_gnt(bus_gnt), .en(en),
        .q(q), .par(par), .strobe(strobe), .err(err)
    );

    bus_tx8 #(.HOLD_CYCLES(4), .TIMEOUT(15)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_data(in_data),
        .in_ready(in_ready4), .bus_req(bus_req4), .bus_gnt(bus_gnt), .en(en4),
        .q(q4), .par(par4), .strobe(strobe4), .err(err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_par(input logic [7:0] d);
        logic p;
        p = ^d;
`ifndef BUS_TX8_PARITY_EN
        p = 1'b0;
`endif
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_valid4 = 1'b0; in_data = 8'hFF; bus_gnt = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++; if (en !== 1'b1) begin n_bad++; $display("FAIL reset_en cyc%0d: got %b want 1", c, en); end
            n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL reset_req cyc%0d: got %b want 0", c, bus_req); end
            n_cmp++; if (q !== 8'h00) begin n_bad++; $display("FAIL reset_q cyc%0d: got %h want 00", c, q); end
            n_cmp++; if ({strobe, err, par} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses cyc%0d: got %b want 000", c, {strobe, err, par}); end
        end
        rst_n = 1'b1; in_valid = 1'b0;
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        n_cmp++; if (en !== 1'b1) begin n_bad++; $display("FAIL reset_en_after: got %b want 1", en); end
    endtask

    // Sends one byte with grant held high; starts in IDLE, ends H+3 cycles later back in IDLE
    task automatic test_granted_byte(input logic [7:0] d);
        logic e_en, e_req, e_stb, e_rdy;
        bus_gnt = 1'b1; in_data = d; in_valid = 1'b1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL tx_ready0 %h: got %b want 1", d, in_ready); end
        for (int c = 1; c <= H + 3; c++) begin
            step();
            in_valid = 1'b0;
            e_en  = !(c >= 2 && c <= 1 + H);
            e_req = (c >= 1 && c <= 1 + H);
            e_stb = (c == 1 + H);
            e_rdy = (c == 3 + H);
            n_cmp++; if (en !== e_en) begin n_bad++; $display("FAIL tx_en %h cyc%0d: got %b want %b", d, c, en, e_en); end
            n_cmp++; if (bus_req !== e_req) begin n_bad++; $display("FAIL tx_req %h cyc%0d: got %b want %b", d, c, bus_req, e_req); end
            n_cmp++; if (strobe !== e_stb) begin n_bad++; $display("FAIL tx_strobe %h cyc%0d: got %b want %b", d, c, strobe, e_stb); end
            n_cmp++; if (in_ready !== e_rdy) begin n_bad++; $display("FAIL tx_ready %h cyc%0d: got %b want %b", d, c, in_ready, e_rdy); end
            n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL tx_err %h cyc%0d: got %b want 0", d, c, err); end
            if (!e_en) begin
                n_cmp++; if (q !== d) begin n_bad++; $display("FAIL tx_q %h cyc%0d: got %h want %h", d, c, q, d); end
                n_cmp++; if (par !== exp_par(d)) begin n_bad++; $display("FAIL tx_par %h cyc%0d: got %b want %b", d, c, par, exp_par(d)); end
            end
        end
    endtask

    task automatic test_timeout();
        logic e_err, e_req, e_rdy;
        bus_gnt = 1'b0; in_data = 8'h3C; in_valid = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step();
            in_valid = 1'b0;
            e_err = (c == 16);
            e_req = (c <= 15);
            e_rdy = (c == 16);
            n_cmp++; if (en !== 1'b1) begin n_bad++; $display("FAIL to_en cyc%0d: got %b want 1", c, en); end
            n_cmp++; if (err !== e_err) begin n_bad++; $display("FAIL to_err cyc%0d: got %b want %b", c, err, e_err); end
            n_cmp++; if (bus_req !== e_req) begin n_bad++; $display("FAIL to_req cyc%0d: got %b want %b", c, bus_req, e_req); end
            n_cmp++; if (in_ready !== e_rdy) begin n_bad++; $display("FAIL to_ready cyc%0d: got %b want %b", c, in_ready, e_rdy); end
        end
        test_granted_byte(8'h81);
    endtask

    task automatic test_grant_loss();
        bus_gnt = 1'b1; in_data = 8'h07; in_valid4 = 1'b1;
        n_cmp++; if (in_ready4 !== 1'b1) begin n_bad++; $display("FAIL gl_ready0: got %b want 1", in_ready4); end
        step();
        in_valid4 = 1'b0;
        n_cmp++; if (bus_req4 !== 1'b1) begin n_bad++; $display("FAIL gl_req1: got %b want 1", bus_req4); end
        step();
        n_cmp++; if (en4 !== 1'b0) begin n_bad++; $display("FAIL gl_en2: got %b want 0", en4); end
        n_cmp++; if (q4 !== 8'h07) begin n_bad++; $display("FAIL gl_q2: got %h want 07", q4); end
        n_cmp++; if (par4 !== exp_par(8'h07)) begin n_bad++; $display("FAIL gl_par2: got %b want %b", par4, exp_par(8'h07)); end
        bus_gnt = 1'b0;
        step();
        n_cmp++; if (en4 !== 1'b1) begin n_bad++; $display("FAIL gl_en3: got %b want 1", en4); end
        n_cmp++; if (err4 !== 1'b1) begin n_bad++; $display("FAIL gl_err3: got %b want 1", err4); end
        n_cmp++; if (bus_req4 !== 1'b0) begin n_bad++; $display("FAIL gl_req3: got %b want 0", bus_req4); end
        n_cmp++; if (in_ready4 !== 1'b0) begin n_bad++; $display("FAIL gl_ready3: got %b want 0", in_ready4); end
        step();
        n_cmp++; if (in_ready4 !== 1'b1) begin n_bad++; $display("FAIL gl_ready4: got %b want 1", in_ready4); end
        n_cmp++; if (err4 !== 1'b0) begin n_bad++; $display("FAIL gl_err4: got %b want 0", err4); end
        for (int c = 5; c <= 7; c++) begin
            step();
            n_cmp++; if ({strobe4, en4} !== 2'b01) begin n_bad++; $display("FAIL gl_quiet cyc%0d: got strobe,en=%b want 01", c, {strobe4, en4}); end
        end
        bus_gnt = 1'b1;
    endtask

    task automatic test_reset_mid();
        bus_gnt = 1'b1; in_data = 8'h5A; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        n_cmp++; if (en !== 1'b0) begin n_bad++; $display("FAIL rm_drive: got en=%b want 0", en); end
        rst_n = 1'b0;
        step();
        n_cmp++; if (en !== 1'b1) begin n_bad++; $display("FAIL rm_en: got %b want 1", en); end
        n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL rm_req: got %b want 0", bus_req); end
        n_cmp++; if (q !== 8'h00) begin n_bad++; $display("FAIL rm_q: got %h want 00", q); end
        n_cmp++; if (strobe !== 1'b0) begin n_bad++; $display("FAIL rm_strobe: got %b want 0", strobe); end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++; if ({strobe, en, in_ready} !== 3'b011) begin n_bad++; $display("FAIL rm_after cyc%0d: got strobe,en,ready=%b want 011", c, {strobe, en, in_ready}); end
        end
    endtask

    task automatic test_back_to_back();
        logic       e_en, e_stb, e_rdy;
        logic [7:0] e_q;
        bus_gnt = 1'b1; in_data = 8'h01; in_valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 1) in_data = 8'hFE;
            if (c == 6) in_valid = 1'b0;
            e_en  = !(c == 2 || c == 3 || c == 7 || c == 8);
            e_stb = (c == 3 || c == 8);
            e_rdy = (c == 5 || c == 10);
            e_q   = (c < 6) ? 8'h01 : 8'hFE;
            n_cmp++; if (en !== e_en) begin n_bad++; $display("FAIL b2b_en cyc%0d: got %b want %b", c, en, e_en); end
            n_cmp++; if (strobe !== e_stb) begin n_bad++; $display("FAIL b2b_strobe cyc%0d: got %b want %b", c, strobe, e_stb); end
            n_cmp++; if (in_ready !== e_rdy) begin n_bad++; $display("FAIL b2b_ready cyc%0d: got %b want %b", c, in_ready, e_rdy); end
            n_cmp++; if (q !== e_q) begin n_bad++; $display("FAIL b2b_q cyc%0d: got %h want %h", c, q, e_q); end
            if (!e_en) begin
                n_cmp++; if (par !== exp_par(e_q)) begin n_bad++; $display("FAIL b2b_par cyc%0d: got %b want %b", c, par, exp_par(e_q)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_granted_byte(8'hA5);
        test_timeout();
        test_grant_loss();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
